pit_io_initiator: RTL and testbench

- Command-driven bus master for the 8254-compatible PIT slave at ports 040h–043h, plus a single-byte writer for speaker port 61h.
- Turns high-level commands into correctly ordered io cycles: load counter, latch-and-read count, read-back status, speaker control.
- Obeys the PIT read timing: the read strobe is honoured on its first cycle only, and read data is registered one cycle later.
- Used by the BIOS-less boot sequencer and the debug bridge to program timers without a CPU.

---
 rtl/pit_pkg.sv | 30 +++
 rtl/pit_io_initiator.sv | 195 +++++++++++++++++++
 tb/tb_pit_io_initiator.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pit_pkg.sv
// Shared constants and state encoding for the PIT io initiator.
package pit_pkg;

  localparam logic [1:0] PIT_OP_LOAD        = 2'd0;
  localparam logic [1:0] PIT_OP_READ_COUNT  = 2'd1;
  localparam logic [1:0] PIT_OP_READ_STATUS = 2'd2;
  localparam logic [1:0] PIT_OP_SPEAKER     = 2'd3;

  localparam logic [1:0] PIT_PORT_CTRL = 2'd3;

  // Control-word field values written to port 043h
  localparam logic [1:0] RW_LSB_MSB = 2'b11;
  localparam logic [1:0] READBACK   = 2'b11;
  localparam logic [1:0] RW_LATCH   = 2'b00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_CTRL,
    ST_WR_LSB,
    ST_WR_MSB,
    ST_WR_SPK,
    ST_RD_REQ_L,
    ST_RD_CAP_L,
    ST_RD_REQ_H,
    ST_RD_CAP_H,
    ST_GAP,
    ST_RESP
  } state_e;

endpackage

// File: rtl/pit_io_initiator.sv
// Command-driven io master for the 8254 PIT (040h-043h) and speaker port 61h.
// Each command becomes an ordered sequence of single-cycle io strobes; reads
// are always split into a request cycle and a capture cycle so the slave sees
// a fresh read edge every time.
module pit_io_initiator
  import pit_pkg::*;
#(
  parameter int IO_GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_sel,
  input  logic [2:0]  cmd_mode,
  input  logic [15:0] cmd_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic [1:0]  io_address,
  output logic        io_read,
  input  logic [7:0]  io_readdata,
  output logic        io_write,
  output logic [7:0]  io_writedata,
  output logic        speaker_61h_write,
  output logic [7:0]  speaker_61h_writedata
);

  localparam bit         HAS_GAP  = (IO_GAP > 0);
  localparam logic [3:0] GAP_INIT = HAS_GAP ? 4'(IO_GAP - 1) : 4'd0;

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;
  logic [3:0]  gap_q, gap_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic [1:0]  op_q, sel_q;
  logic [2:0]  mode_q;
  logic [15:0] data_q;

  logic        ld_cmd;
  logic        access_done;
  state_e      adv;

  assign resp_valid = (state_q == ST_RESP);
  assign cmd_ready  = (state_q == ST_IDLE) && !resp_valid;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

  // Control state: FSM, gap counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_IDLE;
      gap_q       <= 4'd0;
      resp_data_q <= 16'h0000;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      gap_q       <= gap_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Command fields captured at accept; only read while a sequence is active.
  always_ff @(posedge clk) begin
    if (ld_cmd) begin
      op_q   <= cmd_op;
      sel_q  <= cmd_sel;
      mode_q <= cmd_mode;
      data_q <= cmd_data;
    end
  end

  // Next-state and strobe decode; access states hand off to GAP when enabled.
  always_comb begin
    state_d               = state_q;
    ret_d                 = ret_q;
    gap_d                 = gap_q;
    resp_data_d           = resp_data_q;
    resp_err_d            = resp_err_q;
    ld_cmd                = 1'b0;
    access_done           = 1'b0;
    adv                   = ST_IDLE;
    io_address            = 2'd0;
    io_read               = 1'b0;
    io_write              = 1'b0;
    io_writedata          = 8'h00;
    speaker_61h_write     = 1'b0;
    speaker_61h_writedata = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ld_cmd      = 1'b1;
          resp_data_d = 16'h0000;
          resp_err_d  = 1'b0;
          if (cmd_op != PIT_OP_SPEAKER && cmd_sel == 2'd3) begin
            resp_err_d = 1'b1;
            state_d    = ST_RESP;
          end else if (cmd_op == PIT_OP_SPEAKER) begin
            state_d = ST_WR_SPK;
          end else begin
            state_d = ST_WR_CTRL;
          end
        end
      end
      ST_WR_CTRL: begin
        io_write    = 1'b1;
        io_address  = PIT_PORT_CTRL;
        access_done = 1'b1;
        case (op_q)
          PIT_OP_LOAD: begin
            io_writedata = {sel_q, RW_LSB_MSB, mode_q, 1'b0};
            adv          = ST_WR_LSB;
          end
          PIT_OP_READ_COUNT: begin
            io_writedata = {sel_q, RW_LATCH, 4'b0000};
            adv          = ST_RD_REQ_L;
          end
          default: begin
            // Read-back latching status only, for the selected counter
            io_writedata = {READBACK, 1'b1, 1'b0, sel_q == 2'd2,
                            sel_q == 2'd1, sel_q == 2'd0, 1'b0};
            adv          = ST_RD_REQ_L;
          end
        endcase
      end
      ST_WR_LSB: begin
        io_write     = 1'b1;
        io_address   = sel_q;
        io_writedata = data_q[7:0];
        access_done  = 1'b1;
        adv          = ST_WR_MSB;
      end
      ST_WR_MSB: begin
        io_write     = 1'b1;
        io_address   = sel_q;
        io_writedata = data_q[15:8];
        access_done  = 1'b1;
        adv          = ST_RESP;
      end
      ST_WR_SPK: begin
        speaker_61h_write     = 1'b1;
        speaker_61h_writedata = {6'b000000, data_q[1:0]};
        access_done           = 1'b1;
        adv                   = ST_RESP;
      end
      ST_RD_REQ_L: begin
        io_read    = 1'b1;
        io_address = sel_q;
        state_d    = ST_RD_CAP_L;
      end
      ST_RD_CAP_L: begin
        resp_data_d[7:0] = io_readdata;
        access_done      = 1'b1;
        adv              = (op_q == PIT_OP_READ_COUNT) ? ST_RD_REQ_H : ST_RESP;
      end
      ST_RD_REQ_H: begin
        io_read    = 1'b1;
        io_address = sel_q;
        state_d    = ST_RD_CAP_H;
      end
      ST_RD_CAP_H: begin
        resp_data_d[15:8] = io_readdata;
        access_done       = 1'b1;
        adv               = ST_RESP;
      end
      ST_GAP: begin
        if (gap_q == 4'd0) state_d = ret_q;
        else               gap_d   = gap_q - 4'd1;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (access_done) begin
      if (HAS_GAP) begin
        state_d = ST_GAP;
        ret_d   = adv;
        gap_d   = GAP_INIT;
      end else begin
        state_d = adv;
      end
    end
  end

endmodule

// File: tb/tb_pit_io_initiator.sv
// Scoreboard bench for pit_io_initiator: expected bus/response events are
// queued per command and compared against events collected from the DUT.
module tb_pit_io_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        resp_ready = 1'b0;
  logic [1:0]  cmd_op = 2'd0, cmd_sel = 2'd0;
  logic [2:0]  cmd_mode = 3'd0;
  logic [15:0] cmd_data = 16'h0;
  logic [7:0]  io_readdata = 8'h00;
  logic        use2 = 1'b0;

  logic cv0, cv2;
  logic cr0, rv0, re0, ir0, iw0, sw0, cr2, rv2, re2, ir2, iw2, sw2;
  logic [15:0] rd0, rd2;
  logic [1:0]  ia0, ia2;
  logic [7:0]  iwd0, swd0, iwd2, swd2;

  logic s_cr, s_rv, s_re, s_ir, s_iw, s_sw;
  logic [15:0] s_rd;
  logic [1:0]  s_ia;
  logic [7:0]  s_iwd, s_swd;

  assign cv0 = cmd_valid & ~use2;
  assign cv2 = cmd_valid & use2;
  assign s_cr  = use2 ? cr2  : cr0;
  assign s_rv  = use2 ? rv2  : rv0;
  assign s_re  = use2 ? re2  : re0;
  assign s_ir  = use2 ? ir2  : ir0;
  assign s_iw  = use2 ? iw2  : iw0;
  assign s_sw  = use2 ? sw2  : sw0;
  assign s_rd  = use2 ? rd2  : rd0;
  assign s_ia  = use2 ? ia2  : ia0;
  assign s_iwd = use2 ? iwd2 : iwd0;
  assign s_swd = use2 ? swd2 : swd0;

  pit_io_initiator #(.IO_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cv0), .cmd_ready(cr0), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_mode(cmd_mode), .cmd_data(cmd_data),
    .resp_valid(rv0), .resp_ready(resp_ready & ~use2), .resp_data(rd0), .resp_err(re0),
    .io_address(ia0), .io_read(ir0), .io_readdata(io_readdata), .io_write(iw0),
    .io_writedata(iwd0), .speaker_61h_write(sw0), .speaker_61h_writedata(swd0));

  pit_io_initiator #(.IO_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cv2), .cmd_ready(cr2), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_mode(cmd_mode), .cmd_data(cmd_data),
    .resp_valid(rv2), .resp_ready(resp_ready & use2), .resp_data(rd2), .resp_err(re2),
    .io_address(ia2), .io_read(ir2), .io_readdata(io_readdata), .io_write(iw2),
    .io_writedata(iwd2), .speaker_61h_write(sw2), .speaker_61h_writedata(swd2));

  always #5 clk = ~clk;

  // kind: 0 io write, 1 io read, 2 speaker write, 3 resp cycle,
  // 4 after handshake {resp_valid,cmd_ready}, 7 not ready, 8 idle bus not zero, 9 timeout
  typedef struct packed {
    logic [7:0]  cyc;
    logic [3:0]  kind;
    logic [1:0]  addr;
    logic [15:0] data;
    logic        err;
    logic        cr;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  logic [7:0] rd_vals[$];
  int total = 0;
  int bad = 0;

  function automatic ev_t mk(int c, int k, logic [1:0] a, logic [15:0] d, logic e, logic r);
    ev_t v;
    v.cyc = 8'(c); v.kind = 4'(k); v.addr = a; v.data = d; v.err = e; v.cr = r;
    return v;
  endfunction

  // PIT slave: read data appears the cycle after the read strobe
  always @(negedge clk) begin
    if (s_ir && rd_vals.size() > 0) io_readdata = rd_vals.pop_front();
  end

  // Issue one command and record every observable event into obs_q.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] sel, input logic [2:0] mode,
                         input logic [15:0] data, input int hold, input int rst_at, input int maxc);
    int k;
    int held;
    bit done;
    @(negedge clk);
    #1;
    if (!s_cr) obs_q.push_back(mk(0, 7, 2'd0, 16'h0, 1'b0, s_cr));
    cmd_op = op; cmd_sel = sel; cmd_mode = mode; cmd_data = data;
    cmd_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1; held = 0; done = 1'b0;
    while (!done && k <= maxc) begin
      rst = (k == rst_at);
      if (s_iw) obs_q.push_back(mk(k, 0, s_ia, {8'h00, s_iwd}, 1'b0, 1'b0));
      if (s_ir) obs_q.push_back(mk(k, 1, s_ia, 16'h0, 1'b0, 1'b0));
      if (s_sw) obs_q.push_back(mk(k, 2, 2'd0, {8'h00, s_swd}, 1'b0, 1'b0));
      if ((!s_iw && !s_ir && s_ia != 2'd0) || (!s_iw && s_iwd != 8'h00) || (!s_sw && s_swd != 8'h00))
        obs_q.push_back(mk(k, 8, s_ia, {s_iwd, s_swd}, 1'b0, 1'b0));
      if (s_rv) begin
        obs_q.push_back(mk(k, 3, 2'd0, s_rd, s_re, s_cr));
        if (held >= hold) begin
          resp_ready = 1'b1;
          @(posedge clk);
          @(negedge clk);
          resp_ready = 1'b0;
          obs_q.push_back(mk(k + 1, 4, 2'd0, {14'h0, s_rv, s_cr}, 1'b0, 1'b0));
          done = 1'b1;
        end else begin
          held++;
        end
      end
      if (!done) begin
        @(negedge clk);
        k++;
      end
    end
    rst = 1'b0;
    if (!done && rst_at < 0) obs_q.push_back(mk(k, 9, 2'd0, 16'h0, 1'b0, 1'b0));
  endtask

  task automatic test_reset;
    logic [39:0] got;
    logic [39:0] want;
    want = 40'h80_0000_0000;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      if (pass == 1) rst = 1'b0;
      for (int u = 0; u < 2; u++) begin
        use2 = u[0];
        #1;
        got = {s_cr, s_rv, s_rd, s_re, s_ia, s_ir, s_iw, s_iwd, s_sw, s_swd};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL reset pass=%0d dut=%0d got=%h want=%h", pass, u, got, want);
        end
      end
    end
    use2 = 1'b0;
  endtask

  task automatic test_load;
    ev_t e, o;
    exp_q.push_back(mk(1, 0, 2'd3, 16'h0036, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 0, 2'd0, 16'h009C, 1'b0, 1'b0));
    exp_q.push_back(mk(3, 0, 2'd0, 16'h002E, 1'b0, 1'b0));
    exp_q.push_back(mk(4, 3, 2'd0, 16'h0000, 1'b0, 1'b0));
    exp_q.push_back(mk(5, 4, 2'd0, 16'h0001, 1'b0, 1'b0));
    run_cmd(2'd0, 2'd0, 3'd3, 16'h2E9C, 0, -1, 20);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL load events got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL load ev got cyc=%0d kind=%0d raw=%h want cyc=%0d kind=%0d raw=%h", o.cyc, o.kind, o, e.cyc, e.kind, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_read_count;
    ev_t e, o;
    rd_vals.push_back(8'h34); rd_vals.push_back(8'h12);
    exp_q.push_back(mk(1, 0, 2'd3, 16'h0080, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 1, 2'd2, 16'h0000, 1'b0, 1'b0));
    exp_q.push_back(mk(4, 1, 2'd2, 16'h0000, 1'b0, 1'b0));
    exp_q.push_back(mk(6, 3, 2'd0, 16'h1234, 1'b0, 1'b0));
    exp_q.push_back(mk(7, 4, 2'd0, 16'h0001, 1'b0, 1'b0));
    run_cmd(2'd1, 2'd2, 3'd0, 16'h0000, 0, -1, 20);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL rdcnt events got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL rdcnt ev got cyc=%0d kind=%0d raw=%h want cyc=%0d kind=%0d raw=%h", o.cyc, o.kind, o, e.cyc, e.kind, e);
      end
    end
    exp_q.delete(); obs_q.delete(); rd_vals.delete();
  endtask

  task automatic test_read_status;
    ev_t e, o;
    rd_vals.push_back(8'hB6);
    exp_q.push_back(mk(1, 0, 2'd3, 16'h00E4, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 1, 2'd1, 16'h0000, 1'b0, 1'b0));
    exp_q.push_back(mk(4, 3, 2'd0, 16'h00B6, 1'b0, 1'b0));
    exp_q.push_back(mk(5, 4, 2'd0, 16'h0001, 1'b0, 1'b0));
    run_cmd(2'd2, 2'd1, 3'd0, 16'hFFFF, 0, -1, 20);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL rdstat events got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL rdstat ev got cyc=%0d kind=%0d raw=%h want cyc=%0d kind=%0d raw=%h", o.cyc, o.kind, o, e.cyc, e.kind, e);
      end
    end
    exp_q.delete(); obs_q.delete(); rd_vals.delete();
  endtask

  task automatic test_speaker;
    ev_t e, o;
    exp_q.push_back(mk(1, 2, 2'd0, 16'h0003, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 3, 2'd0, 16'h0000, 1'b0, 1'b0));
    exp_q.push_back(mk(3, 4, 2'd0, 16'h0001, 1'b0, 1'b0));
    run_cmd(2'd3, 2'd3, 3'd5, 16'hA5FF, 0, -1, 20);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL spk events got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL spk ev got cyc=%0d kind=%0d raw=%h want cyc=%0d kind=%0d raw=%h", o.cyc, o.kind, o, e.cyc, e.kind, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_illegal_hold;
    ev_t e, o;
    for (int c = 1; c <= 6; c++) exp_q.push_back(mk(c, 3, 2'd0, 16'h0000, 1'b1, 1'b0));
    exp_q.push_back(mk(7, 4, 2'd0, 16'h0001, 1'b0, 1'b0));
    run_cmd(2'd0, 2'd3, 3'd2, 16'h1234, 5, -1, 20);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL illegal events got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL illegal ev got cyc=%0d kind=%0d raw=%h want cyc=%0d kind=%0d raw=%h", o.cyc, o.kind, o, e.cyc, e.kind, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    ev_t e, o;
    rd_vals.push_back(8'h5A);
    exp_q.push_back(mk(1, 0, 2'd3, 16'h0074, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 0, 2'd1, 16'h00FF, 1'b0, 1'b0));
    exp_q.push_back(mk(3, 0, 2'd1, 16'h0000, 1'b0, 1'b0));
    exp_q.push_back(mk(4, 3, 2'd0, 16'h0000, 1'b0, 1'b0));
    exp_q.push_back(mk(5, 4, 2'd0, 16'h0001, 1'b0, 1'b0));
    exp_q.push_back(mk(1, 0, 2'd3, 16'h00E2, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 1, 2'd0, 16'h0000, 1'b0, 1'b0));
    exp_q.push_back(mk(4, 3, 2'd0, 16'h005A, 1'b0, 1'b0));
    exp_q.push_back(mk(5, 4, 2'd0, 16'h0001, 1'b0, 1'b0));
    run_cmd(2'd0, 2'd1, 3'd2, 16'h00FF, 0, -1, 20);
    run_cmd(2'd2, 2'd0, 3'd0, 16'h0000, 0, -1, 20);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL b2b events got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL b2b ev got cyc=%0d kind=%0d raw=%h want cyc=%0d kind=%0d raw=%h", o.cyc, o.kind, o, e.cyc, e.kind, e);
      end
    end
    exp_q.delete(); obs_q.delete(); rd_vals.delete();
  endtask

  task automatic test_gap_reset;
    ev_t e, o;
    logic [39:0] got;
    use2 = 1'b1;
    // Reset during cycle 5 aborts before the MSB write at cycle 7
    exp_q.push_back(mk(1, 0, 2'd3, 16'h0036, 1'b0, 1'b0));
    exp_q.push_back(mk(4, 0, 2'd0, 16'h009C, 1'b0, 1'b0));
    run_cmd(2'd0, 2'd0, 3'd3, 16'h2E9C, 0, 5, 12);
    #1;
    got = {s_cr, s_rv, s_rd, s_re, s_ia, s_ir, s_iw, s_iwd, s_sw, s_swd};
    total++;
    if (got !== 40'h80_0000_0000) begin
      bad++; $display("FAIL gap_rst idle got=%h want=%h", got, 40'h80_0000_0000);
    end
    // Re-issued LOAD with two gap cycles after each access
    exp_q.push_back(mk(1, 0, 2'd3, 16'h0036, 1'b0, 1'b0));
    exp_q.push_back(mk(4, 0, 2'd0, 16'h009C, 1'b0, 1'b0));
    exp_q.push_back(mk(7, 0, 2'd0, 16'h002E, 1'b0, 1'b0));
    exp_q.push_back(mk(10, 3, 2'd0, 16'h0000, 1'b0, 1'b0));
    exp_q.push_back(mk(11, 4, 2'd0, 16'h0001, 1'b0, 1'b0));
    run_cmd(2'd0, 2'd0, 3'd3, 16'h2E9C, 0, -1, 30);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL gap events got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL gap ev got cyc=%0d kind=%0d raw=%h want cyc=%0d kind=%0d raw=%h", o.cyc, o.kind, o, e.cyc, e.kind, e);
      end
    end
    exp_q.delete(); obs_q.delete();
    use2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_read_count();
    test_read_status();
    test_speaker();
    test_illegal_hold();
    test_back_to_back();
    test_gap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
